// File: rtl/l1_dram_arbiter_pkg.sv
// Shared state encodings and grant codes for the L1 I/D-cache DRAM arbiter.
package l1_dram_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_STATE_IDLE  = 2'b00,
        ARB_STATE_GNT_I = 2'b01,
        ARB_STATE_GNT_D = 2'b10
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_I    = 2'b01;
    localparam logic [1:0] GRANT_D    = 2'b10;

endpackage

// File: rtl/l1_arb_timeout_cnt.sv
// Grant watchdog: clears between grants, counts un-acked grant cycles, saturates,
// and pulses expire on the cycle that would bring the count to TIMEOUT.
module l1_arb_timeout_cnt #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expire
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (en && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = en && (cnt >= TERM);

endmodule

// File: rtl/l1_dram_arbiter.sv
// Shares one DRAM port between the L1 I-cache and D-cache controllers.
// Define L1_ARB_ROUND_ROBIN_EN to alternate ties; otherwise the D-cache wins ties.
//
// state            | meaning
// ARB_STATE_IDLE   | no owner, DRAM port quiet, sampling ic_cs/dc_cs
// ARB_STATE_GNT_I  | I-cache owns DRAM until dram_ack or timeout
// ARB_STATE_GNT_D  | D-cache owns DRAM until dram_ack or timeout
module l1_dram_arbiter
    import l1_dram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_cs,
    input  logic              ic_we,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic [DATA_W-1:0] ic_wdata,
    output logic              ic_ack,
    input  logic              dc_cs,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              dram_cs,
    output logic              dram_we,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [DATA_W-1:0] dram_wdata,
    input  logic              dram_ack,
    input  logic [DATA_W-1:0] dram_rdata,
    output logic [1:0]        grant,
    output logic              timeout_err
);

    arb_state_t state, state_nxt;
    logic       granted;
    logic       expire;

    assign granted = (state != ARB_STATE_IDLE);
    assign rdata   = dram_rdata;

    l1_arb_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (!granted),
        .en     (granted && !dram_ack),
        .expire (expire)
    );

`ifdef L1_ARB_ROUND_ROBIN_EN
    logic last_dc;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_dc <= 1'b0;
        end else if (granted && dram_ack) begin
            last_dc <= (state == ARB_STATE_GNT_D);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB_STATE_IDLE;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (expire) begin
                timeout_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_STATE_IDLE: begin
                if (ic_cs && dc_cs) begin
`ifdef L1_ARB_ROUND_ROBIN_EN
                    state_nxt = last_dc ? ARB_STATE_GNT_I : ARB_STATE_GNT_D;
`else
                    state_nxt = ARB_STATE_GNT_D;
`endif
                end else if (dc_cs) begin
                    state_nxt = ARB_STATE_GNT_D;
                end else if (ic_cs) begin
                    state_nxt = ARB_STATE_GNT_I;
                end
            end
            ARB_STATE_GNT_I, ARB_STATE_GNT_D: begin
                // expire is only raised without dram_ack, so a same-cycle ack completes normally
                if (dram_ack || expire) begin
                    state_nxt = ARB_STATE_IDLE;
                end
            end
            default: state_nxt = ARB_STATE_IDLE;
        endcase
    end

    always_comb begin
        dram_cs    = 1'b0;
        dram_we    = 1'b0;
        dram_addr  = '0;
        dram_wdata = '0;
        ic_ack     = 1'b0;
        dc_ack     = 1'b0;
        grant      = GRANT_NONE;
        case (state)
            ARB_STATE_GNT_I: begin
                dram_cs    = 1'b1;
                dram_we    = ic_we;
                dram_addr  = ic_addr;
                dram_wdata = ic_wdata;
                ic_ack     = dram_ack;
                grant      = GRANT_I;
            end
            ARB_STATE_GNT_D: begin
                dram_cs    = 1'b1;
                dram_we    = dc_we;
                dram_addr  = dc_addr;
                dram_wdata = dc_wdata;
                dc_ack     = dram_ack;
                grant      = GRANT_D;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_l1_dram_arbiter.sv
// Directed bench for l1_dram_arbiter built with TIMEOUT=4; honours L1_ARB_ROUND_ROBIN_EN.
module tb_l1_dram_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic              ic_cs, ic_we, dc_cs, dc_we;
    logic [ADDR_W-1:0] ic_addr, dc_addr;
    logic [DATA_W-1:0] ic_wdata, dc_wdata;
    logic              ic_ack, dc_ack;
    logic [DATA_W-1:0] rdata;
    logic              dram_cs, dram_we;
    logic [ADDR_W-1:0] dram_addr;
    logic [DATA_W-1:0] dram_wdata;
    logic              dram_ack;
    logic [DATA_W-1:0] dram_rdata;
    logic [1:0]        grant;
    logic              timeout_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    l1_dram_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (4),
        .CNT_W   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ic_cs       (ic_cs),
        .ic_we       (ic_we),
        .ic_addr     (ic_addr),
        .ic_wdata    (ic_wdata),
        .ic_ack      (ic_ack),
        .dc_cs       (dc_cs),
        .dc_we       (dc_we),
        .dc_addr     (dc_addr),
        .dc_wdata    (dc_wdata),
        .dc_ack      (dc_ack),
        .rdata       (rdata),
        .dram_cs     (dram_cs),
        .dram_we     (dram_we),
        .dram_addr   (dram_addr),
        .dram_wdata  (dram_wdata),
        .dram_ack    (dram_ack),
        .dram_rdata  (dram_rdata),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // inputs change 1 time unit after the rising edge; checks follow a further 1 unit
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [1:0] tie_exp [3];
    logic [DATA_W-1:0] wb_data;

    initial begin
`ifdef L1_ARB_ROUND_ROBIN_EN
        tie_exp[0] = 2'b10; tie_exp[1] = 2'b01; tie_exp[2] = 2'b10;
`else
        tie_exp[0] = 2'b10; tie_exp[1] = 2'b10; tie_exp[2] = 2'b10;
`endif
        wb_data = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

        rst = 1'b1;
        ic_cs = 0; ic_we = 0; ic_addr = '0; ic_wdata = '0;
        dc_cs = 0; dc_we = 0; dc_addr = '0; dc_wdata = '0;
        dram_ack = 0; dram_rdata = '0;
        step(); step();
        rst = 1'b0;
        settle();
        chk("rst_grant", grant, 2'b00);
        chk("rst_dram_cs", dram_cs, 1'b0);
        chk("rst_timeout_err", timeout_err, 1'b0);
        chk("idle_dram_addr", dram_addr, '0);

        // single read, DRAM acks 3 cycles after dram_cs; ack lands on the timeout cycle and wins
        ic_cs = 1; ic_we = 0; ic_addr = 32'h100; ic_wdata = 128'h55;
        step();
        chk("rd_dram_cs", dram_cs, 1'b1);
        chk("rd_dram_addr", dram_addr, 32'h100);
        chk("rd_grant", grant, 2'b01);
        chk("rd_dram_we", dram_we, 1'b0);
        step(); settle();
        chk("rd_no_early_ack", ic_ack, 1'b0);
        step(); step();
        dram_ack = 1; dram_rdata = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        settle();
        chk("rd_ic_ack", ic_ack, 1'b1);
        chk("rd_dc_ack", dc_ack, 1'b0);
        chk("rd_rdata", rdata, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
        step();
        dram_ack = 0; ic_cs = 0;
        settle();
        chk("rd_idle_grant", grant, 2'b00);
        chk("rd_ack_dropped", ic_ack, 1'b0);
        chk("rd_no_timeout", timeout_err, 1'b0);

        // three back-to-back ties
        for (int r = 0; r < 3; r++) begin
            ic_cs = 1; dc_cs = 1; ic_addr = 32'h300 + r; dc_addr = 32'h400 + r;
            step();
            chk($sformatf("tie%0d_grant", r), grant, tie_exp[r]);
            dram_ack = 1;
            settle();
            chk($sformatf("tie%0d_ic_ack", r), ic_ack, tie_exp[r][0]);
            chk($sformatf("tie%0d_dc_ack", r), dc_ack, tie_exp[r][1]);
            step();
            dram_ack = 0; ic_cs = 0; dc_cs = 0;
            step();
        end

        // D-cache write-back with an I-cache fill queued behind it
        dc_cs = 1; dc_we = 1; dc_addr = 32'h2000; dc_wdata = wb_data;
        step();
        ic_cs = 1; ic_we = 0; ic_addr = 32'h500;
        settle();
        chk("wb_grant", grant, 2'b10);
        chk("wb_dram_we", dram_we, 1'b1);
        chk("wb_dram_addr", dram_addr, 32'h2000);
        chk("wb_dram_wdata", dram_wdata, wb_data);
        step();
        chk("wb_hold_wdata", dram_wdata, wb_data);
        dram_ack = 1;
        settle();
        chk("wb_dc_ack", dc_ack, 1'b1);
        chk("wb_ic_ack", ic_ack, 1'b0);
        step();
        dram_ack = 0; dc_cs = 0; dc_we = 0;
        settle();
        chk("wb_gap_grant", grant, 2'b00);
        chk("wb_gap_wdata", dram_wdata, '0);
        step();
        chk("wb_next_grant", grant, 2'b01);
        chk("wb_next_addr", dram_addr, 32'h500);
        dram_ack = 1;
        settle();
        chk("wb_next_ic_ack", ic_ack, 1'b1);
        step();
        dram_ack = 0; ic_cs = 0;

        // timeout: grant held 4 cycles with no ack
        ic_cs = 1; ic_addr = 32'h600;
        step();
        chk("to_grant_c1", grant, 2'b01);
        step(); step(); step();
        chk("to_grant_c4", grant, 2'b01);
        chk("to_err_c4", timeout_err, 1'b0);
        step();
        ic_cs = 0;
        settle();
        chk("to_idle", grant, 2'b00);
        chk("to_err_set", timeout_err, 1'b1);
        chk("to_no_ack", ic_ack, 1'b0);

        // sticky flag across a good transfer
        dc_cs = 1; dc_we = 0; dc_addr = 32'h700;
        step();
        chk("sticky_grant", grant, 2'b10);
        dram_ack = 1;
        settle();
        chk("sticky_dc_ack", dc_ack, 1'b1);
        step();
        dram_ack = 0; dc_cs = 0;
        settle();
        chk("sticky_err", timeout_err, 1'b1);

        // reset mid-grant, then a stray ack in IDLE
        dc_cs = 1; dc_addr = 32'h800;
        step();
        chk("mid_grant", grant, 2'b10);
        rst = 1;
        step();
        rst = 0; dc_cs = 0;
        settle();
        chk("mid_dram_cs", dram_cs, 1'b0);
        chk("mid_grant_idle", grant, 2'b00);
        chk("mid_dc_ack", dc_ack, 1'b0);
        chk("mid_err_cleared", timeout_err, 1'b0);
        step();
        dram_ack = 1;
        settle();
        chk("stray_dc_ack", dc_ack, 1'b0);
        chk("stray_ic_ack", ic_ack, 1'b0);
        step();
        dram_ack = 0;
        settle();
        chk("stray_state", grant, 2'b00);
        chk("stray_dram_cs", dram_cs, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
